// File: rtl/fetch_stage.sv
// fetch_stage: PC, IF/ID register and RUN/HALT fetch FSM; FETCH_PERF_EN adds fetch/stall perf counters.
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR  = 32'hE1A0_0000,
    parameter logic [31:0] HALT_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_f,
    input  logic        stall_d,
    input  logic        flush_d,
    input  logic        branch_taken_e,
    input  logic [31:0] branch_target_e,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rd,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic [31:0] pc_plus8_d,
    output logic        valid_d,
    output logic        halted,
    output logic [31:0] fetch_count,
    output logic [31:0] stall_count
);
    typedef enum logic {RUN, HALT} state_t;
    state_t state;
    logic [31:0] pc_f;
    logic bubble, capture, halt_hit;
    assign imem_addr = pc_f;
    assign bubble    = flush_d || branch_taken_e;
    assign capture   = !bubble && !stall_d && state == RUN;
    assign halt_hit  = capture && imem_rd == HALT_INSTR;
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_f       <= RESET_PC;
            state      <= RUN;
            halted     <= 1'b0;
            instr_d    <= NOP_INSTR;
            pc_d       <= '0;
            pc_plus8_d <= '0;
            valid_d    <= 1'b0;
        end else begin
            // the halt word's own capture freezes the PC at the halt address
            if (branch_taken_e)
                pc_f <= branch_target_e & ~32'h3;
            else if (!(state == HALT || stall_f || halt_hit))
                pc_f <= pc_f + 32'd4;
            if (bubble || (!stall_d && state == HALT)) begin
                instr_d <= NOP_INSTR;
                valid_d <= 1'b0;
            end else if (capture) begin
                instr_d    <= imem_rd;
                pc_d       <= pc_f;
                pc_plus8_d <= pc_f + 32'd8;
                valid_d    <= 1'b1;
            end
            if (branch_taken_e) begin
                state  <= RUN;
                halted <= 1'b0;
            end else if (halt_hit) begin
                state  <= HALT;
                halted <= 1'b1;
            end
        end
    end
`ifdef FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_count <= '0;
            stall_count <= '0;
        end else begin
            if (capture)
                fetch_count <= fetch_count + 32'd1;
            if (stall_d && valid_d && !bubble)
                stall_count <= stall_count + 32'd1;
        end
    end
`else
    assign fetch_count = '0;
    assign stall_count = '0;
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scoreboard bench for fetch_stage against a small aliased ROM model.
module tb_fetch_stage;
    localparam logic [31:0] NOP = 32'hE1A0_0000;
    logic clk = 1'b0;
    logic reset, stall_f, stall_d, flush_d, branch_taken_e, valid_d, halted;
    logic [31:0] branch_target_e, imem_addr, imem_rd, instr_d, pc_d, pc_plus8_d, fetch_count, stall_count;
    logic [31:0] rom [64];
    int checks = 0;
    int failures = 0;
    typedef struct {
        logic [31:0] a, i, p, p8;
        logic v, h;
    } exp_t;
    exp_t exp_q[$];

    fetch_stage dut (
        .clk(clk), .reset(reset), .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d),
        .branch_taken_e(branch_taken_e), .branch_target_e(branch_target_e),
        .imem_addr(imem_addr), .imem_rd(imem_rd), .instr_d(instr_d), .pc_d(pc_d),
        .pc_plus8_d(pc_plus8_d), .valid_d(valid_d), .halted(halted),
        .fetch_count(fetch_count), .stall_count(stall_count)
    );

    always #5 clk = ~clk;
    assign imem_rd = rom[imem_addr[7:2]];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step(input logic [31:0] a, input logic [31:0] i, input logic [31:0] p,
                        input logic [31:0] p8, input logic v, input logic h);
        exp_t e;
        exp_q.push_back('{a, i, p, p8, v, h});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk("imem_addr", imem_addr, e.a);
        chk("instr_d", instr_d, e.i);
        chk("pc_d", pc_d, e.p);
        chk("pc_plus8_d", pc_plus8_d, e.p8);
        chk("valid_d", {31'd0, valid_d}, {31'd0, e.v});
        chk("halted", {31'd0, halted}, {31'd0, e.h});
    endtask

    task automatic drive(input logic sf, input logic sd, input logic fl, input logic br, input logic [31:0] tgt);
        stall_f = sf;
        stall_d = sd;
        flush_d = fl;
        branch_taken_e = br;
        branch_target_e = tgt;
    endtask

    initial begin
        for (int k = 0; k < 64; k++) rom[k] = 32'h0;
        rom[0] = 32'hE04F_000F;
        rom[1] = 32'hE3A0_101E;
        rom[2] = 32'hE3A0_2011;
        for (int k = 3; k < 13; k++) rom[k] = 32'hE280_0000 | k;
        rom[63] = 32'hE3A0_F0AA;
        reset = 1'b1;
        drive(0, 0, 0, 0, 32'h0);
        step(32'h0, NOP, 32'h0, 32'h0, 0, 0);
        chk("fetch_count_rst", fetch_count, 32'h0);
        chk("stall_count_rst", stall_count, 32'h0);
        reset = 1'b0;
        step(32'h4, 32'hE04F_000F, 32'h0, 32'h8, 1, 0);
        step(32'h8, 32'hE3A0_101E, 32'h4, 32'hC, 1, 0);
        drive(1, 1, 0, 0, 32'h0);
        repeat (3) step(32'h8, 32'hE3A0_101E, 32'h4, 32'hC, 1, 0);
        drive(0, 0, 0, 0, 32'h0);
        step(32'hC, 32'hE3A0_2011, 32'h8, 32'h10, 1, 0);
`ifdef FETCH_PERF_EN
        chk("stall_count_3", stall_count, 32'd3);
        chk("fetch_count_3", fetch_count, 32'd3);
`else
        chk("stall_count_off", stall_count, 32'd0);
        chk("fetch_count_off", fetch_count, 32'd0);
`endif
        step(32'h10, 32'hE280_0003, 32'hC, 32'h14, 1, 0);
        step(32'h14, 32'hE280_0004, 32'h10, 32'h18, 1, 0);
        drive(1, 1, 0, 1, 32'h0000_0023);
        step(32'h20, NOP, 32'h10, 32'h18, 0, 0);
        drive(0, 0, 0, 0, 32'h0);
        for (int k = 8; k < 13; k++)
            step(32'h4 * (k + 1), 32'hE280_0000 | k, 32'h4 * k, 32'h4 * k + 32'h8, 1, 0);
        step(32'h34, 32'h0, 32'h34, 32'h3C, 1, 1);
        repeat (2) step(32'h34, NOP, 32'h34, 32'h3C, 0, 1);
        drive(0, 0, 0, 1, 32'h0);
        step(32'h0, NOP, 32'h34, 32'h3C, 0, 0);
        drive(0, 0, 0, 0, 32'h0);
        step(32'h4, 32'hE04F_000F, 32'h0, 32'h8, 1, 0);
        drive(0, 0, 0, 1, 32'hFFFF_FFFC);
        step(32'hFFFF_FFFC, NOP, 32'h0, 32'h8, 0, 0);
        drive(0, 0, 0, 0, 32'h0);
        step(32'h0, 32'hE3A0_F0AA, 32'hFFFF_FFFC, 32'h4, 1, 0);
        drive(0, 0, 0, 1, 32'h34);
        step(32'h34, NOP, 32'hFFFF_FFFC, 32'h4, 0, 0);
        drive(0, 0, 0, 0, 32'h0);
        step(32'h34, 32'h0, 32'h34, 32'h3C, 1, 1);
        drive(1, 1, 0, 0, 32'h0);
        step(32'h34, 32'h0, 32'h34, 32'h3C, 1, 1);
        reset = 1'b1;
        step(32'h0, NOP, 32'h0, 32'h0, 0, 0);
        chk("fetch_count_rst2", fetch_count, 32'h0);
        chk("stall_count_rst2", stall_count, 32'h0);
        reset = 1'b0;
        drive(0, 0, 0, 0, 32'h0);
        step(32'h4, 32'hE04F_000F, 32'h0, 32'h8, 1, 0);
        drive(0, 0, 1, 0, 32'h0);
        step(32'h8, NOP, 32'h0, 32'h8, 0, 0);
        drive(0, 0, 0, 0, 32'h0);
        step(32'hC, 32'hE3A0_2011, 32'h8, 32'h10, 1, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
